// File: rtl/mag_calctr_pkg.sv
// Shared widths, FSM encoding and helpers for the vector magnitude calculator.
package mag_calctr_pkg;

    localparam int OP_W   = 8;
    localparam int RAD_W  = 16;
    localparam int ROOT_W = 8;
    localparam int ITERS  = 8;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's complement magnitude; -128 maps to 128 as an unsigned byte.
    function automatic logic [OP_W-1:0] abs8(input logic [OP_W-1:0] v);
        return v[OP_W-1] ? (~v + 8'd1) : v;
    endfunction

endpackage

// File: rtl/isqrt16_seq.sv
// Restoring bit-pair square root, one result bit per clock, MSB pair first.
module isqrt16_seq
    import mag_calctr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [RAD_W-1:0]  radicand,
    output logic [ROOT_W-1:0] root,
    output logic              done
);

    logic [RAD_W-1:0] rad_q;
    logic [9:0]       rem_q;
    logic [2:0]       cnt;
    logic             busy;
    logic [11:0]      rem_sh;
    logic [11:0]      trial;
    logic             take;

    assign rem_sh = {rem_q, rad_q[RAD_W-1 -: 2]};
    assign trial  = {2'b00, root, 2'b01};
    assign take   = rem_sh >= trial;
    // Final iteration is in flight; root is complete after this edge.
    assign done   = busy && (cnt == 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_q <= '0;
            rem_q <= '0;
            root  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            rad_q <= radicand;
            rem_q <= '0;
            root  <= '0;
            cnt   <= 3'(ITERS - 1);
            busy  <= 1'b1;
        end else if (busy) begin
            rad_q <= rad_q << 2;
            if (take) begin
                rem_q <= 10'(rem_sh - trial);
                root  <= {root[ROOT_W-2:0], 1'b1};
            end else begin
                rem_q <= rem_sh[9:0];
                root  <= {root[ROOT_W-2:0], 1'b0};
            end
            cnt <= cnt - 3'd1;
            if (cnt == 3'd0) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/mag_calctr.sv
// Free-running floor(sqrt(X^2+Y^2)) calculator; new result every 10 clocks.
module mag_calctr
    import mag_calctr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t           state;
    logic [OP_W-1:0]  ax;
    logic [OP_W-1:0]  ay;
    logic [RAD_W-1:0] radicand;
    logic [ROOT_W-1:0] root;
    logic             done;
    logic             start;
    logic             unused_ena;

    assign ax       = abs8(ui_in);
    assign ay       = abs8(uio_in);
    assign radicand = ({8'd0, ax} * {8'd0, ax}) + ({8'd0, ay} * {8'd0, ay});
    assign start    = (state == LOAD);

    assign uio_out    = 8'h00;
    assign uio_oe     = 8'h00;
    assign unused_ena = ena;

    isqrt16_seq u_sqrt (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .radicand (radicand),
        .root     (root),
        .done     (done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LOAD;
            uo_out <= '0;
        end else begin
            unique case (state)
                LOAD: state <= ITER;
                ITER: if (done) state <= DONE;
                DONE: begin
                    uo_out <= root;
                    state  <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_mag_calctr.sv
// Self-checking bench: directed cases plus random sweep against a sqrt model.
module tb_mag_calctr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_run  = 0;
    int n_fail = 0;
    int prev   = 0;

    mag_calctr dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model(input logic [7:0] x, input logic [7:0] y);
        int sx, sy, s, r;
        sx = $signed(x);
        sy = $signed(y);
        s  = sx * sx + sy * sy;
        r  = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    // Inputs x/y present at the LOAD edge; nx/ny applied mid-ITER.
    task automatic run_pair(input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] nx, input logic [7:0] ny,
                            input string tag);
        int exp;
        ui_in  = x;
        uio_in = y;
        exp    = model(x, y);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            ena = 1'($urandom);
            if (i == 3) begin
                ui_in  = nx;
                uio_in = ny;
            end
            if (i < 10) check({tag, "_hold"}, uo_out, prev);
        end
        check({tag, "_tie"}, {uio_out, uio_oe}, 0);
        check(tag, uo_out, exp);
        prev = exp;
    endtask

    initial begin
        logic [7:0] rx, ry;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'd3;
        uio_in = 8'd4;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", uo_out, 0);
        check("rst_tie", {uio_out, uio_oe}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_pair(8'd3, 8'd4, 8'd3, 8'd4, "x3y4");
        run_pair(8'h80, 8'h80, 8'h80, 8'h80, "max");
        run_pair(8'd127, 8'd0, 8'd127, 8'd0, "x127");
        run_pair(8'hFB, 8'd12, 8'hFB, 8'd12, "neg5y12");
        run_pair(8'd0, 8'd0, 8'd0, 8'd0, "zero");
        run_pair(8'd1, 8'd1, 8'd1, 8'd1, "one");
        run_pair(8'd3, 8'd4, 8'd6, 8'd8, "midchg1");
        run_pair(8'd6, 8'd8, 8'd6, 8'd8, "midchg2");

        // Abort mid-ITER, then expect a fresh result 10 clocks after release
        ui_in  = 8'd3;
        uio_in = 8'd4;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", uo_out, 0);
        prev = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_pair(8'd3, 8'd4, 8'd3, 8'd4, "post_rst");

        for (int k = 0; k < 200; k++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            run_pair(rx, ry, rx, ry, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
